seq_multiplier: RTL and testbench
=================================

// Module: seq_multiplier
// PURPOSE
//   Parametrised iterative shift-add multiplier for the ALU multiplier path.
//   Each cycle it forms one partial product (multiplicand AND-gated by one multiplier bit)
//   and accumulates it, so WIDTH cycles replace a full combinational partial-product array.
//   Supports unsigned and signed (two's complement) operands with a start/done handshake.
// PARAMETERS
//   WIDTH   32   operand width in bits (>= 2); product is 2*WIDTH bits
//   CNT_W   6    iteration counter width; must satisfy 2**CNT_W > WIDTH
// PORTS
//   clk        in   1        system clock, all state on rising edge
//   rst_n      in   1        synchronous active-low reset
//   start      in   1        request: sample a, b, is_signed this cycle (accepted only when !busy)
//   is_signed  in   1        1 = two's complement operands, 0 = unsigned
//   a          in   WIDTH    multiplicand
//   b          in   WIDTH    multiplier
//   busy       out  1        1 while an operation is in progress
//   done       out  1        one-cycle pulse: product valid
//   product    out  2*WIDTH  result; held stable until the next completion
// BEHAVIOUR
//   Reset (rst_n=0 at a clk edge): state=IDLE, busy=0, done=0, product=0, internal regs cleared.
//   FSM states: IDLE, RUN.
//   IDLE: if start=1 -> capture operands, busy<=1, cnt<=0, go RUN; else stay. done<=0 unless completing.
//   Capture: signed mode: mcand=|a|, mplier=|b| (WIDTH-bit unsigned magnitudes),
//     neg=a[WIDTH-1]^b[WIDTH-1]; unsigned mode: mcand=a, mplier=b, neg=0. hi<=0.
//   RUN, each cycle: pp = mcand & {WIDTH{lo[0]}}; sum = {1'b0,hi} + pp (WIDTH+1 bits);
//     {hi,lo} <= {sum,lo} >> 1 (lo initially holds mplier); cnt<=cnt+1.
//   After the WIDTH-th RUN cycle (cnt==WIDTH-1): product <= neg ? -{hi,lo} : {hi,lo},
//     done<=1, busy<=0, go IDLE.
//   Latency: start sampled at edge T -> RUN edges T+1..T+WIDTH -> done=1 and product valid
//     in cycle after edge T+WIDTH, for exactly one cycle. Throughput: one op per WIDTH+1 cycles.
//   start while busy=1: ignored, no effect on in-flight operation; inputs need not be held.
//   start in the done-pulse cycle: accepted (busy=0 there); product keeps old value
//     until the new operation completes.
//   Width rule: magnitude of most-negative operand (2**(WIDTH-1)) fits in WIDTH unsigned bits;
//     signed min*min = 2**(2*WIDTH-2) fits in 2*WIDTH signed; no overflow case exists.
//   Zero operand: runs full WIDTH cycles, product=0, neg ignored (-0 = 0).
//   Reset mid-operation: abandons op; no done pulse; product returns to 0.
//   No combinational path from inputs to outputs; all outputs registered.
// TESTING
//   1. WIDTH=32, unsigned, a=3, b=5, start 1 cycle -> busy=1 for 32 cycles, done pulse at
//      cycle 33 after start, product=0x000000000000000F.
//   2. Unsigned a=b=0xFFFFFFFF -> product=0xFFFFFFFE00000001; signed same -> product=1.
//   3. Signed a=0xFFFFFFFD (-3), b=7 -> 0xFFFFFFFFFFFFFFEB; signed a=b=0x80000000
//      -> 0x4000000000000000.
//   4. Pulse start again at cycles 5 and 20 of an op with different operands -> ignored,
//      first result correct; start in done cycle -> accepted, next done 33 cycles later.
//   5. Drop rst_n for 1 cycle at RUN cycle 10 -> busy=0, done never pulses, product=0;
//      new start afterwards completes correctly.
//   6. WIDTH=8, CNT_W=4: random 1000 signed/unsigned pairs vs reference model,
//      done exactly 9 cycles after each accepted start.

Source files
------------

// File: rtl/seq_multiplier.sv
// seq_multiplier
//   Iterative shift-add multiplier for the ALU multiplier path. The block forms one
//   partial product per cycle and accumulates it, so an operation takes WIDTH cycles.
//   Signed operands are converted to magnitudes at capture time. The sign of the
//   result is then applied once, when the operation completes.
//
// Parameters
//   WIDTH  operand width in bits (>= 2); the product is 2*WIDTH bits wide
//   CNT_W  iteration counter width; 2**CNT_W must be greater than WIDTH
//
// Ports
//   clk        system clock; all state changes on the rising edge
//   rst_n      synchronous active-low reset
//   start      request to sample a, b and is_signed; accepted only while not busy
//   is_signed  1 = two's complement operands, 0 = unsigned operands
//   a          multiplicand
//   b          multiplier
//   busy       high while an operation is in progress
//   done       one-cycle pulse when product holds a new result
//   product    result; held stable until the next completion
module seq_multiplier #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               is_signed,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_t             state, state_next;
  logic [WIDTH-1:0]   mcand, mcand_next;
  logic [WIDTH-1:0]   hi, hi_next;
  logic [WIDTH-1:0]   lo, lo_next;
  logic [CNT_W-1:0]   cnt, cnt_next;
  logic               neg, neg_next;
  logic               busy_next, done_next;
  logic [2*WIDTH-1:0] product_next;

  logic [WIDTH-1:0]   a_mag, b_mag, pp;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] acc;

  // Negating the most negative value wraps back to itself. Read as unsigned, that is
  // exactly its magnitude, so no extra bit is needed.
  assign a_mag = a[WIDTH-1] ? -a : a;
  assign b_mag = b[WIDTH-1] ? -b : b;

  // One shift-add step. The carry out of the add becomes the new top bit of hi.
  // The multiplier bit that was just consumed drops off the bottom of lo.
  assign pp  = mcand & {WIDTH{lo[0]}};
  assign sum = {1'b0, hi} + {1'b0, pp};
  assign acc = {sum, lo[WIDTH-1:1]};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      mcand   <= '0;
      hi      <= '0;
      lo      <= '0;
      cnt     <= '0;
      neg     <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      product <= '0;
    end else begin
      state   <= state_next;
      mcand   <= mcand_next;
      hi      <= hi_next;
      lo      <= lo_next;
      cnt     <= cnt_next;
      neg     <= neg_next;
      busy    <= busy_next;
      done    <= done_next;
      product <= product_next;
    end
  end

  always_comb begin
    state_next   = state;
    mcand_next   = mcand;
    hi_next      = hi;
    lo_next      = lo;
    cnt_next     = cnt;
    neg_next     = neg;
    busy_next    = busy;
    done_next    = 1'b0;
    product_next = product;

    unique case (state)
      IDLE: begin
        if (start) begin
          mcand_next = is_signed ? a_mag : a;
          lo_next    = is_signed ? b_mag : b;
          neg_next   = is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
          hi_next    = '0;
          cnt_next   = '0;
          busy_next  = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        hi_next  = acc[2*WIDTH-1:WIDTH];
        lo_next  = acc[WIDTH-1:0];
        cnt_next = cnt + CNT_W'(1);
        if (cnt == LAST_CNT) begin
          // Negating a zero magnitude gives zero, so neg needs no special case here.
          product_next = neg ? -acc : acc;
          done_next    = 1'b1;
          busy_next    = 1'b0;
          state_next   = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_seq_multiplier.sv
// tb_seq_multiplier
//   Directed checks of seq_multiplier. A 32-bit instance covers the main operations,
//   start being ignored while busy, back-to-back starts and reset during an operation.
//   An 8-bit instance covers the small-width corner products.
module tb_seq_multiplier;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, is_signed;
  logic [31:0] a, b;
  logic        busy, done;
  logic [63:0] product;

  logic        start8, is_signed8;
  logic [7:0]  a8, b8;
  logic        busy8, done8;
  logic [15:0] product8;

  int assertCount = 0;
  int failCount   = 0;

  always #5 clk = ~clk;

  seq_multiplier #(.WIDTH(32), .CNT_W(6)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .is_signed(is_signed),
    .a(a), .b(b), .busy(busy), .done(done), .product(product)
  );

  seq_multiplier #(.WIDTH(8), .CNT_W(4)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .is_signed(is_signed8),
    .a(a8), .b(b8), .busy(busy8), .done(done8), .product(product8)
  );

  typedef struct {
    string       tag;
    logic [31:0] va;
    logic [31:0] vb;
    logic        sgn;
    logic [63:0] expected;
  } vec32_t;

  typedef struct {
    string       tag;
    logic [7:0]  va;
    logic [7:0]  vb;
    logic        sgn;
    logic [15:0] expected;
  } vec8_t;

  // Compares one observed value against its expected value.
  // It counts the comparison and reports a mismatch.
  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Pulses start for one cycle, then scrambles the operands.
  // The task returns at the negedge after the sampling edge, which is cycle 1 of the operation.
  task automatic applyStimulus(input logic [31:0] ia, input logic [31:0] ib, input logic isg);
    @(negedge clk);
    a = ia; b = ib; is_signed = isg; start = 1'b1;
    @(negedge clk);
    start = 1'b0; a = ~ia; b = ~ib; is_signed = ~isg;
  endtask

  // Counts cycles from cycle 1 until done is seen, within a bounded budget.
  // With interfere set, the task also pulses start with other operands at cycles 5 and 20.
  task automatic waitDone(input string tag, input bit interfere, output int lat);
    lat = 1;
    while (done !== 1'b1 && lat < 100) begin
      @(negedge clk);
      lat++;
      if (interfere && (lat == 5 || lat == 20)) begin
        start = 1'b1; a = 32'd7; b = 32'd9; is_signed = 1'b1;
      end else begin
        start = 1'b0;
      end
    end
    if (lat >= 100) checkOutput({tag, " timeout"}, 64'd0, 64'd1);
  endtask

  // Runs one complete operation and checks busy, latency, product, the single-cycle
  // done pulse and that the product holds after the pulse.
  task automatic runOp(input string tag, input logic [31:0] ia, input logic [31:0] ib,
                       input logic isg, input logic [63:0] expected);
    int lat;
    applyStimulus(ia, ib, isg);
    checkOutput({tag, " busy"}, 64'(busy), 64'd1);
    waitDone(tag, 1'b0, lat);
    checkOutput({tag, " latency"}, 64'(lat), 64'd33);
    checkOutput({tag, " product"}, product, expected);
    checkOutput({tag, " busy at done"}, 64'(busy), 64'd0);
    @(negedge clk);
    checkOutput({tag, " done pulse"}, 64'(done), 64'd0);
    checkOutput({tag, " product hold"}, product, expected);
  endtask

  // Runs one operation on the 8-bit instance and checks its latency and product.
  task automatic runOp8(input string tag, input logic [7:0] ia, input logic [7:0] ib,
                        input logic isg, input logic [15:0] expected);
    int lat;
    @(negedge clk);
    a8 = ia; b8 = ib; is_signed8 = isg; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0; a8 = ~ia; b8 = ~ib;
    lat = 1;
    while (done8 !== 1'b1 && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    checkOutput({tag, " latency"}, 64'(lat), 64'd9);
    checkOutput({tag, " product"}, 64'(product8), 64'(expected));
  endtask

  vec32_t vecs[6] = '{
    '{"u 3x5",        32'd3,          32'd5,          1'b0, 64'h0000_0000_0000_000F},
    '{"u max x max",  32'hFFFF_FFFF,  32'hFFFF_FFFF,  1'b0, 64'hFFFF_FFFE_0000_0001},
    '{"s -1 x -1",    32'hFFFF_FFFF,  32'hFFFF_FFFF,  1'b1, 64'h0000_0000_0000_0001},
    '{"s -3 x 7",     32'hFFFF_FFFD,  32'd7,          1'b1, 64'hFFFF_FFFF_FFFF_FFEB},
    '{"s min x min",  32'h8000_0000,  32'h8000_0000,  1'b1, 64'h4000_0000_0000_0000},
    '{"s 0 x -5",     32'd0,          32'hFFFF_FFFB,  1'b1, 64'h0000_0000_0000_0000}
  };

  vec8_t vecs8[5] = '{
    '{"w8 u FFxFF",   8'hFF, 8'hFF, 1'b0, 16'hFE01},
    '{"w8 s min2",    8'h80, 8'h80, 1'b1, 16'h4000},
    '{"w8 s -3x7",    8'hFD, 8'h07, 1'b1, 16'hFFEB},
    '{"w8 s 127x-128",8'h7F, 8'h80, 1'b1, 16'hC080},
    '{"w8 u 80x03",   8'h80, 8'h03, 1'b0, 16'h0180}
  };

  initial begin
    int lat;
    int doneSeen;

    rst_n = 1'b0; start = 1'b0; is_signed = 1'b0; a = '0; b = '0;
    start8 = 1'b0; is_signed8 = 1'b0; a8 = '0; b8 = '0;
    repeat (3) @(negedge clk);
    checkOutput("reset busy", 64'(busy), 64'd0);
    checkOutput("reset done", 64'(done), 64'd0);
    checkOutput("reset product", product, 64'd0);
    checkOutput("reset busy8", 64'(busy8), 64'd0);
    rst_n = 1'b1;

    foreach (vecs[i]) runOp(vecs[i].tag, vecs[i].va, vecs[i].vb, vecs[i].sgn, vecs[i].expected);

    // A start while busy must not disturb the in-flight operation.
    applyStimulus(32'd100, 32'd200, 1'b0);
    waitDone("ignore start", 1'b1, lat);
    checkOutput("ignore start latency", 64'(lat), 64'd33);
    checkOutput("ignore start product", product, 64'd20000);

    // A start during the done cycle is accepted, and the old product stays until the new one completes.
    a = 32'd6; b = 32'd7; is_signed = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0; a = '0; b = '0;
    checkOutput("b2b busy", 64'(busy), 64'd1);
    checkOutput("b2b done low", 64'(done), 64'd0);
    checkOutput("b2b old product", product, 64'd20000);
    waitDone("b2b", 1'b0, lat);
    checkOutput("b2b latency", 64'(lat), 64'd33);
    checkOutput("b2b product", product, 64'd42);

    // Reset at cycle 10 of an operation abandons it.
    applyStimulus(32'd3, 32'd5, 1'b0);
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checkOutput("midreset busy", 64'(busy), 64'd0);
    checkOutput("midreset done", 64'(done), 64'd0);
    checkOutput("midreset product", product, 64'd0);
    doneSeen = 0;
    repeat (40) begin
      @(negedge clk);
      if (done === 1'b1) doneSeen++;
    end
    checkOutput("midreset no done", 64'(doneSeen), 64'd0);
    runOp("after reset 12x13", 32'd12, 32'd13, 1'b0, 64'd156);

    foreach (vecs8[i]) runOp8(vecs8[i].tag, vecs8[i].va, vecs8[i].vb, vecs8[i].sgn, vecs8[i].expected);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
